mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute unit.
- Accepts one completed execute result per handshake: ALU result or address, store data, memory op and destination register.
- For loads and stores, it runs a request/response transaction on the data bus, then aligns and extends load data.
- For every instruction, it emits a one-cycle writeback pulse to the register-file write stage.

---
 rtl/mem_pkg.sv | 67 ++++++
 rtl/load_align.sv | 31 +++
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: op codes, FSM states,
// access sizes and byte-lane strobe patterns.
package mem_pkg;

  localparam int MEMOP_W = 4;

  typedef enum logic [MEMOP_W-1:0] {
    MEM_NONE = 4'd0,
    LB, LH, LW, LD,
    LBU, LHU, LWU,
    SB, SH, SW, SD
  } memop_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  function automatic logic [1:0] op_size(input memop_t op);
    case (op)
      LB, LBU, SB: op_size = SZ_B;
      LH, LHU, SH: op_size = SZ_H;
      LW, LWU, SW: op_size = SZ_W;
      default:     op_size = SZ_D;
    endcase
  endfunction

  function automatic logic is_load(input memop_t op);
    is_load = (op inside {LB, LH, LW, LD, LBU, LHU, LWU});
  endfunction

  function automatic logic is_store(input memop_t op);
    is_store = (op inside {SB, SH, SW, SD});
  endfunction

  function automatic logic [7:0] size_strb(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_strb = STRB_B;
      SZ_H:    size_strb = STRB_H;
      SZ_W:    size_strb = STRB_W;
      default: size_strb = STRB_D;
    endcase
  endfunction

  // Natural alignment: the offset must be a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off[1:0];
      SZ_D:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: shifts the addressed bytes of a 64-bit bus word
// down to bit 0 and sign- or zero-extends them according to the load op.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]    raw,
  input  logic [2:0]         off,
  input  logic [MEMOP_W-1:0] memop,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0] shifted;

  assign shifted = raw >> {off, 3'b000};

  always_comb begin
    result = shifted;
    case (memop_t'(memop))
      LB:      result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:      result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LW:      result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LBU:     result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU:     result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LWU:     result = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one execute result at a time, runs a single
// request/response bus transaction for loads and stores, and emits a writeback pulse.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_res,
  input  logic [XLEN-1:0]    in_wdata,
  input  logic [MEMOP_W-1:0] in_memop,
  input  logic [RD_W-1:0]    in_rd,
  input  logic               in_wen,
  output logic               dreq_valid,
  input  logic               dreq_ready,
  output logic [XLEN-1:0]    dreq_addr,
  output logic               dreq_wen,
  output logic [7:0]         dreq_strb,
  output logic [XLEN-1:0]    dreq_wdata,
  input  logic               dresp_valid,
  input  logic [XLEN-1:0]    dresp_data,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_data,
  output logic [RD_W-1:0]    out_rd,
  output logic               out_wen,
  output logic               out_misalign
);

  state_t          state_reg, state_next;
  memop_t          memop_reg, memop_next;
  logic [2:0]      off_reg, off_next;
  logic [RD_W-1:0] rd_reg, rd_next;
  logic            wen_reg, wen_next;

  logic            dreq_valid_reg, dreq_valid_next;
  logic [XLEN-1:0] dreq_addr_reg, dreq_addr_next;
  logic            dreq_wen_reg, dreq_wen_next;
  logic [7:0]      dreq_strb_reg, dreq_strb_next;
  logic [XLEN-1:0] dreq_wdata_reg, dreq_wdata_next;

  logic            out_valid_reg, out_valid_next;
  logic [XLEN-1:0] out_data_reg, out_data_next;
  logic [RD_W-1:0] out_rd_reg, out_rd_next;
  logic            out_wen_reg, out_wen_next;
  logic            out_misalign_reg, out_misalign_next;

  memop_t          in_op;
  logic [1:0]      in_size;
  logic [2:0]      in_off;
  logic [XLEN-1:0] load_result;

  assign in_op   = memop_t'(in_memop);
  assign in_size = op_size(in_op);
  assign in_off  = in_res[2:0];

  load_align #(.XLEN(XLEN)) u_load_align (
    .raw    (dresp_data),
    .off    (off_reg),
    .memop  (memop_reg),
    .result (load_result)
  );

  always_comb begin
    state_next        = state_reg;
    memop_next        = memop_reg;
    off_next          = off_reg;
    rd_next           = rd_reg;
    wen_next          = wen_reg;
    dreq_valid_next   = dreq_valid_reg;
    dreq_addr_next    = dreq_addr_reg;
    dreq_wen_next     = dreq_wen_reg;
    dreq_strb_next    = dreq_strb_reg;
    dreq_wdata_next   = dreq_wdata_reg;
    out_valid_next    = 1'b0;
    out_data_next     = out_data_reg;
    out_rd_next       = out_rd_reg;
    out_wen_next      = 1'b0;
    out_misalign_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          memop_next = in_op;
          off_next   = in_off;
          rd_next    = in_rd;
          wen_next   = in_wen;
          if (!is_load(in_op) && !is_store(in_op)) begin
            out_valid_next = 1'b1;
            out_data_next  = in_res;
            out_rd_next    = in_rd;
            out_wen_next   = in_wen;
          end else if (misaligned(in_size, in_off)) begin
            // Report the faulting address without touching the bus.
            out_valid_next    = 1'b1;
            out_data_next     = in_res;
            out_rd_next       = in_rd;
            out_misalign_next = 1'b1;
          end else begin
            state_next      = REQ;
            dreq_valid_next = 1'b1;
            dreq_addr_next  = {in_res[XLEN-1:3], 3'b000};
            dreq_wen_next   = is_store(in_op);
            dreq_strb_next  = is_store(in_op) ? (size_strb(in_size) << in_off) : 8'h00;
            dreq_wdata_next = is_store(in_op) ? (in_wdata << {in_off, 3'b000}) : '0;
          end
        end
      end
      REQ: begin
        if (dreq_ready) begin
          state_next      = WAIT;
          dreq_valid_next = 1'b0;
        end
      end
      WAIT: begin
        // The response is aligned on arrival so DONE only has to present it.
        if (dresp_valid) begin
          state_next     = DONE;
          out_valid_next = 1'b1;
          out_rd_next    = rd_reg;
          if (is_load(memop_reg)) begin
            out_data_next = load_result;
            out_wen_next  = wen_reg;
          end else begin
            out_data_next = '0;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      memop_reg        <= MEM_NONE;
      off_reg          <= '0;
      rd_reg           <= '0;
      wen_reg          <= 1'b0;
      dreq_valid_reg   <= 1'b0;
      dreq_addr_reg    <= '0;
      dreq_wen_reg     <= 1'b0;
      dreq_strb_reg    <= '0;
      dreq_wdata_reg   <= '0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_rd_reg       <= '0;
      out_wen_reg      <= 1'b0;
      out_misalign_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      memop_reg        <= memop_next;
      off_reg          <= off_next;
      rd_reg           <= rd_next;
      wen_reg          <= wen_next;
      dreq_valid_reg   <= dreq_valid_next;
      dreq_addr_reg    <= dreq_addr_next;
      dreq_wen_reg     <= dreq_wen_next;
      dreq_strb_reg    <= dreq_strb_next;
      dreq_wdata_reg   <= dreq_wdata_next;
      out_valid_reg    <= out_valid_next;
      out_data_reg     <= out_data_next;
      out_rd_reg       <= out_rd_next;
      out_wen_reg      <= out_wen_next;
      out_misalign_reg <= out_misalign_next;
    end
  end

  assign in_ready     = (state_reg == IDLE);
  assign dreq_valid   = dreq_valid_reg;
  assign dreq_addr    = dreq_addr_reg;
  assign dreq_wen     = dreq_wen_reg;
  assign dreq_strb    = dreq_strb_reg;
  assign dreq_wdata   = dreq_wdata_reg;
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_rd       = out_rd_reg;
  assign out_wen      = out_wen_reg;
  assign out_misalign = out_misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized
// transactions compared against a byte-level behavioural model.
module tb_mem_stage;
  import mem_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        in_res;
  logic [63:0]        in_wdata;
  logic [MEMOP_W-1:0] in_memop;
  logic [4:0]         in_rd;
  logic               in_wen;
  logic               dreq_valid;
  logic               dreq_ready;
  logic [63:0]        dreq_addr;
  logic               dreq_wen;
  logic [7:0]         dreq_strb;
  logic [63:0]        dreq_wdata;
  logic               dresp_valid;
  logic [63:0]        dresp_data;
  logic               out_valid;
  logic [63:0]        out_data;
  logic [4:0]         out_rd;
  logic               out_wen;
  logic               out_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_res       (in_res),
    .in_wdata     (in_wdata),
    .in_memop     (in_memop),
    .in_rd        (in_rd),
    .in_wen       (in_wen),
    .dreq_valid   (dreq_valid),
    .dreq_ready   (dreq_ready),
    .dreq_addr    (dreq_addr),
    .dreq_wen     (dreq_wen),
    .dreq_strb    (dreq_strb),
    .dreq_wdata   (dreq_wdata),
    .dresp_valid  (dresp_valid),
    .dresp_data   (dresp_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_wen      (out_wen),
    .out_misalign (out_misalign)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int op_bytes(input memop_t op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, LWU, SW: return 4;
      default:     return 8;
    endcase
  endfunction

  // Pick the addressed bytes out of the bus word and extend them.
  function automatic logic [63:0] model_load(input memop_t op, input int off, input logic [63:0] word);
    int          nb;
    logic [63:0] v;
    logic [63:0] mask;
    nb = op_bytes(op);
    v  = word >> (8 * off);
    if (nb == 8) return v;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if ((op == LB || op == LH || op == LW) && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input memop_t op, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input logic [4:0] rd, input logic wen,
                         input int stall, input int delay);
    int          nb;
    int          off;
    bit          is_mem;
    bit          is_st;
    bit          misal;
    logic [63:0] exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_out;
    nb     = op_bytes(op);
    off    = int'(addr % 8);
    is_mem = (op != MEM_NONE);
    is_st  = (op == SB || op == SH || op == SW || op == SD);
    misal  = is_mem && ((addr % nb) != 0);

    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_memop = op;
    in_res   = addr;
    in_wdata = wdata;
    in_rd    = rd;
    in_wen   = wen;
    tick();
    in_valid = 1'b0;
    in_res   = {$urandom, $urandom};
    in_wdata = {$urandom, $urandom};

    if (!is_mem || misal) begin
      check("imm_out_valid", out_valid, 1);
      check("imm_out_data", out_data, addr);
      check("imm_out_rd", out_rd, rd);
      check("imm_out_wen", out_wen, misal ? 1'b0 : wen);
      check("imm_out_misalign", out_misalign, misal);
      check("imm_no_dreq", dreq_valid, 0);
      tick();
      check("imm_pulse_end", out_valid, 0);
    end else begin
      exp_strb  = is_st ? (((64'd1 << nb) - 64'd1) << off) : 64'd0;
      exp_wdata = wdata << (8 * off);
      for (int i = 0; i <= stall; i++) begin
        dreq_ready  = (i == stall);
        dresp_valid = (i < stall) ? 1'($urandom_range(0, 1)) : 1'b0;
        dresp_data  = {$urandom, $urandom};
        check("req_valid", dreq_valid, 1);
        check("req_addr", dreq_addr, addr & ~64'd7);
        check("req_wen", dreq_wen, is_st);
        check("req_strb", dreq_strb, exp_strb);
        if (is_st) check("req_wdata", dreq_wdata, exp_wdata);
        check("req_in_ready", in_ready, 0);
        check("req_no_out", out_valid, 0);
        tick();
      end
      dreq_ready  = 1'b0;
      dresp_valid = 1'b0;
      check("wait_dreq_low", dreq_valid, 0);
      for (int i = 0; i < delay; i++) begin
        check("wait_no_out", out_valid, 0);
        check("wait_in_ready", in_ready, 0);
        tick();
      end
      dresp_valid = 1'b1;
      dresp_data  = rdata;
      tick();
      dresp_valid = 1'b0;
      dresp_data  = {$urandom, $urandom};
      exp_out = is_st ? 64'd0 : model_load(op, off, rdata);
      check("done_out_valid", out_valid, 1);
      check("done_out_data", out_data, exp_out);
      check("done_out_rd", out_rd, rd);
      check("done_out_wen", out_wen, is_st ? 1'b0 : wen);
      check("done_out_misalign", out_misalign, 0);
      check("done_in_ready", in_ready, 0);
      tick();
      check("done_pulse_end", out_valid, 0);
    end
    $display("txn op=%0d addr=0x%h rd=%0d stall=%0d delay=%0d checks=%0d", op, addr, rd, stall, delay, n_checks);
  endtask

  initial begin
    memop_t      op;
    logic [63:0] addr;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_res      = '0;
    in_wdata    = '0;
    in_memop    = MEM_NONE;
    in_rd       = '0;
    in_wen      = 1'b0;
    dreq_ready  = 1'b0;
    dresp_valid = 1'b0;
    dresp_data  = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_dreq_strb", dreq_strb, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_misalign", out_misalign, 0);
    rst = 1'b0;
    tick();

    run_txn(MEM_NONE, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 0, 0);
    run_txn(LB, 64'h1003, 64'h0, 64'h00000000_80000000, 5'd7, 1'b1, 0, 0);
    run_txn(SH, 64'h2006, 64'hBEEF, 64'h0, 5'd0, 1'b0, 4, 0);
    run_txn(LW, 64'h3002, 64'h0, 64'h0, 5'd9, 1'b1, 0, 0);

    // A response while idle must not produce writeback.
    dresp_valid = 1'b1;
    dresp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    dresp_valid = 1'b0;
    check("idle_resp_ignored", out_valid, 0);
    check("idle_resp_ready", in_ready, 1);
    run_txn(LWU, 64'h4004, 64'h0, 64'h89ABCDEF_00000000, 5'd11, 1'b1, 0, 3);

    // Reset while waiting for a response, then a late response.
    in_valid = 1'b1;
    in_memop = LD;
    in_res   = 64'h5000;
    in_rd    = 5'd3;
    in_wen   = 1'b1;
    tick();
    in_valid   = 1'b0;
    dreq_ready = 1'b1;
    tick();
    dreq_ready = 1'b0;
    check("rst_mid_wait_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_dreq_valid", dreq_valid, 0);
    dresp_valid = 1'b1;
    dresp_data  = 64'h1111_2222_3333_4444;
    tick();
    dresp_valid = 1'b0;
    check("late_resp_out_valid", out_valid, 0);
    tick();
    check("late_resp_out_valid2", out_valid, 0);
    check("late_resp_in_ready", in_ready, 1);

    for (int n = 0; n < 60; n++) begin
      op   = memop_t'($urandom_range(0, 11));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) addr = addr & ~(64'(op_bytes(op)) - 64'd1);
      run_txn(op, addr, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
